mem_bus_bridge: RTL and testbench

Data-side memory system directly downstream of the single-cycle ARM core. It consumes the core's MemWrite, ALUResult (address) and WriteData, and returns ReadData in the same cycle. It contains the data RAM and a buffered pixel-command port toward the 2D graphics engine, with a status/clear register. The core never stalls, so pixel-command overflow is recorded rather than back-pressured.

---
 rtl/mem_map_pkg.sv | 37 +++
 rtl/cmd_fifo.sv | 56 +++++
 rtl/mem_bus_bridge.sv | 97 +++++++++
 tb/tb_mem_bus_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, STATUS field layout and region decode shared by the data-side
// memory system of the single-cycle core.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE        = 32'h0000_0000;
  localparam logic [31:0] PIXEL_CMD_ADDR  = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR     = 32'h0000_1004;
  localparam logic [31:0] STATUS_CLR_ADDR = 32'h0000_1008;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_DROP_LSB  = 16;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PIXEL,
    REG_STATUS,
    REG_CLR,
    REG_NONE
  } region_e;

  // The caller passes the word address (byte bits already stripped), so every
  // remaining bit takes part in the compare and aliases above the map decode
  // to REG_NONE.
  function automatic region_e decode(input logic [29:0] waddr, input int ram_words);
    logic [31:0] ram_limit;
    ram_limit = 32'(ram_words);
    if ({2'b00, waddr} - {2'b00, RAM_BASE[31:2]} < ram_limit) return REG_RAM;
    if (waddr == PIXEL_CMD_ADDR[31:2])  return REG_PIXEL;
    if (waddr == STATUS_ADDR[31:2])     return REG_STATUS;
    if (waddr == STATUS_CLR_ADDR[31:2]) return REG_CLR;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO. A push to a full FIFO is still
// taken when a pop happens in the same cycle, so the count stays at DEPTH.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_fire;
  logic          push_fire;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head      = mem[rd_ptr];
  assign pop_fire  = pop && !empty;
  assign push_fire = push && (!full || pop_fire);

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are live, so stale words are never observable.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Data-side memory system for the single-cycle core: data RAM with same-cycle
// reads, buffered pixel-command port and a sticky overflow/drop status.
module mem_bus_bridge
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        cmd_valid,
  output logic [31:0] cmd_data,
  input  logic        cmd_ready,
  output logic        overflow
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  region_e         region;
  logic [31:0]     ram [RAM_WORDS];
  logic [RAW-1:0]  ram_idx;
  logic            push_req;
  logic            rejected;
  logic            clr_req;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [15:0]     drop_count;
  logic [31:0]     status;
  logic            unused_lsbs;

  assign region      = decode(ALUResult[31:2], RAM_WORDS);
  assign ram_idx     = ALUResult[RAW+1:2];
  assign unused_lsbs = ^ALUResult[1:0];

  assign push_req = MemWrite && (region == REG_PIXEL);
  assign clr_req  = MemWrite && (region == REG_CLR);
  // A full FIFO is never empty, so a ready consumer always frees a slot.
  assign rejected = push_req && fifo_full && !cmd_ready;

  always_ff @(posedge clk) begin
    if (MemWrite && region == REG_RAM) ram[ram_idx] <= WriteData;
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_req),
    .push_data (WriteData),
    .pop       (cmd_ready),
    .head      (cmd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_req) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (rejected) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_DROP_LSB +: 16] = drop_count;
    status[ST_COUNT_LSB +: 8] = 8'(fifo_count);
    status[ST_OVERFLOW]       = overflow;
    status[ST_FULL]           = fifo_full;
    status[ST_EMPTY]          = fifo_empty;
  end

  // NOTE: ReadData is given a default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:    ReadData = ram[ram_idx];
      REG_STATUS: ReadData = status;
      default:    ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: directed scenarios then random traffic,
// checked against a queue/array model of the memory map.
module tb_mem_bus_bridge;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        overflow;

  mem_bus_bridge #(.RAM_WORDS(1024), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];        // model FIFO contents
  logic [31:0] sb_q[$];      // scoreboard of words expected on the cmd port
  logic [31:0] ram_m [int];  // model RAM, only written words
  logic        ovf_m = 1'b0;
  int          drops_m = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rd;
  logic        last_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n = mq.size();
    return {16'(drops_m), 8'(n), 5'b0, ovf_m, (n == DEPTH), (n == 0)};
  endfunction

  // One bus cycle: drive, check combinational outputs mid-cycle, then apply
  // the clock edge to the model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic rst_v);
    logic [31:0] wa;
    bit          pop, push_req, full;
    MemWrite = we; ALUResult = a; WriteData = wd; cmd_ready = rdy; reset = rst_v;
    wa = a & 32'hFFFF_FFFC;
    @(negedge clk);
    last_rd    = ReadData;
    last_valid = cmd_valid;
    if (wa < 32'h1000) begin
      if (ram_m.exists(int'(wa >> 2))) check("ram_read", ReadData, ram_m[int'(wa >> 2)]);
    end else if (wa == 32'h1004) begin
      check("status_read", ReadData, model_status());
    end else begin
      check("unmapped_read", ReadData, 32'h0);
    end
    check("cmd_valid", {31'b0, cmd_valid}, {31'b0, mq.size() != 0});
    check("overflow", {31'b0, overflow}, {31'b0, ovf_m});
    @(posedge clk);
    if (we && wa < 32'h1000) ram_m[int'(wa >> 2)] = wd;
    if (!rst_v) begin
      mq.delete(); sb_q.delete(); ovf_m = 1'b0; drops_m = 0;
    end else begin
      pop      = (mq.size() != 0) && rdy;
      push_req = we && (wa == 32'h1000);
      full     = (mq.size() == DEPTH);
      if (push_req && full && !pop) begin
        ovf_m = 1'b1;
        if (drops_m < 16'hFFFF) drops_m++;
      end
      if (we && wa == 32'h1008) begin
        ovf_m = 1'b0; drops_m = 0;
      end
      if (pop) void'(mq.pop_front());
      if (push_req && (!full || pop)) begin
        mq.push_back(wd); sb_q.push_back(wd);
      end
    end
    #1;
  endtask

  // Monitor: the head must match the scoreboard whenever valid; a handshake
  // retires it.
  always @(negedge clk) begin
    if (mon_en && cmd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL cmd_unexpected: got 0x%08h expected no word at %0t", cmd_data, $time);
      end else begin
        check("cmd_data", cmd_data, sb_q[0]);
        if (cmd_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    MemWrite = 0; ALUResult = 0; WriteData = 0; cmd_ready = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset state
    step(0, 32'h1004, 0, 0, 1);
    check("reset_status", last_rd, 32'h0000_0001);
    check("reset_valid", {31'b0, last_valid}, 32'h0);

    // RAM store then load
    step(1, 32'h10, 32'hDEAD_BEEF, 0, 1);
    step(0, 32'h10, 0, 0, 1);
    check("ram_store_load", last_rd, 32'hDEAD_BEEF);
    step(0, 32'h2000, 0, 0, 1);
    check("unmapped_zero", last_rd, 32'h0);

    // Three pushes held, then drained in order
    for (int i = 1; i <= 3; i++) step(1, 32'h1000, 32'(i), 0, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("status_three", last_rd, 32'h0000_0300);
    repeat (3) step(0, 32'h1000, 0, 1, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("status_drained", last_rd, 32'h0000_0001);

    // Overflow: 18 pushes into 16 slots, then clear
    for (int i = 0; i < 18; i++) step(1, 32'h1000, 32'h100 + 32'(i), 0, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("status_overflow", last_rd, 32'h0002_1006);
    step(1, 32'h1008, 0, 0, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("status_cleared", last_rd, 32'h0000_1002);

    // Full with simultaneous pop and push: no drop
    step(1, 32'h1000, 32'hAA, 1, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("status_full_pop_push", last_rd, 32'h0000_1002);
    repeat (DEPTH) step(0, 0, 0, 1, 1);
    check("aa_drained_last", {31'b0, sb_q.size() == 0}, {31'b0, 1'b1});

    // Reset with entries queued and overflow set; push in reset cycle dropped
    for (int i = 0; i < 17; i++) step(1, 32'h1000, 32'h200 + 32'(i), 0, 1);
    repeat (11) step(0, 0, 0, 1, 1);
    step(0, 32'h1004, 0, 0, 1);
    check("pre_reset_status", last_rd, 32'h0001_0504);
    step(1, 32'h1000, 32'h55, 0, 0);
    step(0, 32'h1004, 0, 0, 1);
    check("post_reset_status", last_rd, 32'h0000_0001);
    check("post_reset_valid", {31'b0, last_valid}, 32'h0);

    // Push and pop attempt on an empty FIFO
    step(1, 32'h1000, 32'h77, 1, 1);
    check("empty_push_valid_now", {31'b0, last_valid}, 32'h0);
    step(0, 0, 0, 0, 1);
    check("empty_push_valid_next", {31'b0, last_valid}, 32'h1);
    step(0, 0, 0, 1, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int          op;
      logic [31:0] a, wd;
      logic        we, rdy, rst_v;
      op    = int'($urandom_range(0, 9));
      rdy   = ($urandom_range(0, 2) == 0);
      rst_v = ($urandom_range(0, 299) != 0);
      wd    = $urandom;
      we    = 1'b0;
      a     = 32'h1004;
      case (op)
        0, 1:    begin we = 1; a = {$urandom_range(0, 31), 2'($urandom)}; end
        2:       a = {$urandom_range(0, 31), 2'b00};
        3, 4, 5: begin we = 1; a = 32'h1000; end
        6:       a = 32'h1004;
        7:       begin we = ($urandom_range(0, 3) == 0); a = 32'h1008; end
        8:       begin we = 1; a = 32'h0000_2000 + {$urandom_range(0, 3), 2'b00}; end
        default: begin we = $urandom_range(0, 1); a = 32'hFFFF_F000; end
      endcase
      if (!rst_v && a < 32'h1000) we = 1'b0;
      step(we, a, wd, rdy, rst_v);
    end

    repeat (DEPTH + 2) step(0, 32'h1004, 0, 1, 1);
    check("final_scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
